// File: rtl/pc8001_video_timing.sv
// PC-8001 video timing: pixel enable, h/v counters, sync/blank/de,
// NTSC/PAL frame length and RGB expansion to 8 bits per channel.
module pc8001_video_timing #(
  parameter int CLK_DIV      = 4,
  parameter int IN_BITS      = 4,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 200,
  parameter int V_FP         = 16,
  parameter int V_SYNC       = 3,
  parameter int V_TOTAL_NTSC = 262,
  parameter int V_TOTAL_PAL  = 312
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               pal,
  input  logic [IN_BITS-1:0] r_in,
  input  logic [IN_BITS-1:0] g_in,
  input  logic [IN_BITS-1:0] b_in,
  output logic               ce_pix,
  output logic [10:0]        hcnt,
  output logic [9:0]         vcnt,
  output logic               hsync,
  output logic               vsync,
  output logic               hblank,
  output logic               vblank,
  output logic               de,
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b,
  output logic               frame_start,
  output logic               pal_active
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  VN_LAST = 10'(V_TOTAL_NTSC - 1);
  localparam logic [9:0]  VP_LAST = 10'(V_TOTAL_PAL - 1);

  logic [DW-1:0] r_div;
  logic [10:0]   r_hcnt;
  logic [9:0]    r_vcnt;
  logic          r_hs, r_vs, r_hb, r_vb, r_de;
  logic [7:0]    r_r, r_g, r_b;
  logic          r_fs, r_pal;

  logic       w_ce, w_h_end, w_v_end;
  logic       w_hb, w_hs, w_vb, w_vs, w_de;
  logic [9:0] w_v_last;

  // MSB-first replication of the narrow channel, truncated to 8 bits
  function automatic logic [7:0] expand(input logic [IN_BITS-1:0] c);
    logic [7:0] e;
    for (int i = 0; i < 8; i++)
      e[7-i] = c[IN_BITS-1-(i%IN_BITS)];
    return e;
  endfunction

  assign w_ce     = (r_div == DIV_MAX);
  assign w_v_last = r_pal ? VP_LAST : VN_LAST;
  assign w_h_end  = (r_hcnt == H_LAST);
  assign w_v_end  = (r_vcnt == w_v_last);
  assign w_hb     = (r_hcnt >= H_ACT);
  assign w_hs     = (r_hcnt >= HS_ON) && (r_hcnt < HS_OFF);
  assign w_vb     = (r_vcnt >= V_ACT);
  assign w_vs     = (r_vcnt >= VS_ON) && (r_vcnt < VS_OFF);
  assign w_de     = ~(w_hb | w_vb);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_div  <= '0;
      r_hcnt <= '0;
      r_vcnt <= '0;
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
      r_hb   <= 1'b0;
      r_vb   <= 1'b0;
      r_de   <= 1'b0;
      r_r    <= '0;
      r_g    <= '0;
      r_b    <= '0;
      r_fs   <= 1'b0;
      r_pal  <= 1'b0;
    end else begin
      r_div <= w_ce ? '0 : r_div + 1'b1;
      r_fs  <= 1'b0;
      if (w_ce) begin
        r_hs <= w_hs;
        r_vs <= w_vs;
        r_hb <= w_hb;
        r_vb <= w_vb;
        r_de <= w_de;
        r_r  <= w_de ? expand(r_in) : 8'd0;
        r_g  <= w_de ? expand(g_in) : 8'd0;
        r_b  <= w_de ? expand(b_in) : 8'd0;
        r_fs <= (r_hcnt == 11'd0) && (r_vcnt == 10'd0);
        if (w_h_end) begin
          r_hcnt <= '0;
          // mode only switches on the last pixel of a frame
          if (w_v_end) begin
            r_vcnt <= '0;
            r_pal  <= pal;
          end else begin
            r_vcnt <= r_vcnt + 10'd1;
          end
        end else begin
          r_hcnt <= r_hcnt + 11'd1;
        end
      end
    end
  end

  assign ce_pix      = w_ce;
  assign hcnt        = r_hcnt;
  assign vcnt        = r_vcnt;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign hblank      = r_hb;
  assign vblank      = r_vb;
  assign de          = r_de;
  assign vga_r       = r_r;
  assign vga_g       = r_g;
  assign vga_b       = r_b;
  assign frame_start = r_fs;
  assign pal_active  = r_pal;

endmodule

// File: doc/pc8001_video_timing.md
# pc8001_video_timing

Parametrised video timing and output stage for the PC-8001 core. It generates the pixel clock enable, horizontal/vertical counters, sync, blank and data-enable signals from a single system clock, with selectable NTSC/PAL line counts. It expands the machine's narrow RGB into the 8-bit-per-channel VGA_* signals at the emu top level. It replaces the hard-wired pass-through of sync and colour, and adds the CE_PIXEL, VGA_DE and TV-mode behaviour the top level needs.

## Interface
Parameters:
- CLK_DIV, 4: clk_sys cycles per pixel (≥2)
- IN_BITS, 4: width of each input colour channel (1..8)
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, in pixels
- H_SYNC, 96: hsync width, in pixels
- H_BP, 48: horizontal back porch; H_TOTAL = sum of the four = 800
- V_ACTIVE, 200: visible lines
- V_FP, 16: vertical front porch, in lines
- V_SYNC, 3: vsync width, in lines
- V_TOTAL_NTSC, 262: lines per frame, NTSC mode
- V_TOTAL_PAL, 312: lines per frame, PAL mode

Ports:
- clk_sys  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- pal  in  1  requested mode: 0 = NTSC, 1 = PAL (status[2])
- r_in, g_in, b_in  in  IN_BITS each  pixel colour at the current (hcnt, vcnt)
- ce_pix  out  1  pixel enable, one clk_sys cycle wide
- hcnt  out  11  position of the next pixel to be sampled
- vcnt  out  10  position of the next line
- hsync, vsync  out  1  active-high sync
- hblank, vblank  out  1  blanking flags
- de  out  1  ~(hblank|vblank)
- vga_r, vga_g, vga_b  out  8 each  expanded colour; 0 when blanked
- frame_start  out  1  one-cycle pulse aligned with output of pixel (0,0)
- pal_active  out  1  mode currently in effect

## Operation
Divider and counters:
- A divider counts 0..CLK_DIV-1 and wraps. ce_pix is high in the cycle where divider == CLK_DIV-1.
- On each ce_pix, output registers load values computed from the current hcnt/vcnt and r/g/b_in. The counters then advance.
- hcnt wraps H_TOTAL-1 → 0 and increments vcnt. vcnt wraps Vt-1 → 0, where Vt = pal_active ? V_TOTAL_PAL : V_TOTAL_NTSC.

Flags, computed from (hcnt, vcnt):
- hblank = hcnt ≥ H_ACTIVE
- hsync = H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC
- vblank = vcnt ≥ V_ACTIVE
- vsync = V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC

Colour expansion:
- Each channel is replicated MSB-first and truncated to 8 bits. For IN_BITS=4, 0xA → 0xAA. For IN_BITS=3, 3'b101 → 8'b10110110. For IN_BITS=1, 1 → 0xFF.
- When the flags give a blanked pixel, vga_* load 0.

Mode latch:
- pal_active loads pal only on the ce_pix where hcnt == H_TOTAL-1 and vcnt == Vt-1, i.e. the last pixel of the frame.
- Changes to pal mid-frame are ignored until that point.
- The new Vt applies starting with the frame that follows.

frame_start:
- High for the single clk_sys cycle following the ce_pix that sampled (0,0).

## Timing
- Reset, including reset asserted mid-frame: on the next clk_sys edge the divider, hcnt, vcnt, ce_pix, hsync, vsync, hblank, vblank, de, vga_*, frame_start and pal_active all go to 0.
- After reset, counting restarts from (0,0) in NTSC mode.
- First ce_pix occurs on the CLK_DIV-th cycle after reset is deasserted.
- Latency: inputs are sampled on ce_pix. All video outputs change in the cycle after that ce_pix and hold for CLK_DIV cycles. hcnt/vcnt lead the video outputs by one pixel.
- Frame period: H_TOTAL × Vt × CLK_DIV clk_sys cycles. With defaults: NTSC 838,400 cycles, PAL 998,400 cycles.
- Inputs are assumed stable only at ce_pix. No other handshake.

## Test plan
- Reset and divider: hold reset 5 cycles, release. All outputs are 0 and pal_active = 0. First ce_pix appears on cycle 4 after release, then repeats every 4 cycles.
- Horizontal timing (NTSC): hsync is high for output pixels 656..751 (96 pixels). hblank is high for 640..799. Line = 3200 cycles.
- Vertical timing (NTSC): vsync is high for lines 216..218. frame_start pulses are 838,400 cycles apart. vcnt max = 261.
- Colour path: r_in = 4'hA, g_in = 4'h3, b_in = 4'hF at (10,10) gives vga = AA/33/FF and de = 1. The same input at hcnt = 700 gives vga = 0 and de = 0.
- Mode switch: set pal = 1 at line 100. The current frame still ends after line 261 and pal_active stays 0 until then. Next frame has 312 lines and pal_active = 1.
- Reset mid-frame at (300,150): next cycle all outputs are 0. After release, hcnt/vcnt restart at 0 and pal_active = 0.
